// File: rtl/volume_ctrl.sv
// volume_ctrl: front-panel controller for the volume attenuator.
// Debounces up/down/mute buttons, issues one-cycle up/down step pulses,
// keeps a shadow copy of the attenuation shift, and ramps mute/unmute
// one step per RAMP_CYCLES.
// Optional feature macro: VOLUME_CTRL_AUTOREPEAT_EN (hold-to-repeat in IDLE).
module volume_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RAMP_CYCLES     = 8,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 32
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       up_btn_i,
  input  logic       down_btn_i,
  input  logic       mute_btn_i,
  output logic       up_o,
  output logic       down_o,
  output logic [2:0] level_o,
  output logic       muted_o,
  output logic       busy_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int RT_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam logic [RT_W-1:0] RT_MAX = RT_W'(RAMP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RAMP_MUTE, MUTED, RAMP_UNMUTE} state_t;

  // Button vectors are ordered {mute, down, up}.
  logic [2:0]      raw;
  logic [2:0]      sync1, sync2, deb, deb_q, press;
  logic [DB_W-1:0] db_cnt [3];

  state_t          state, state_n;
  logic [2:0]      saved_r, saved_n;
  logic [RT_W-1:0] tmr, tmr_n;
  logic            up_n, down_n;
  logic [2:0]      level_nx, unmute_tgt;
  logic            rpt_up, rpt_dn, req_up, req_dn;

  assign raw   = {mute_btn_i, down_btn_i, up_btn_i};
  assign press = deb & ~deb_q;

  // Two-flop synchronizers and per-button saturating debounce counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef VOLUME_CTRL_AUTOREPEAT_EN
  localparam int RP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  logic [RP_W-1:0] rp_cnt;
  logic            rp_act, rp_hold, rp_fire;

  assign rp_fire = rp_act && (rp_hold ? (rp_cnt == RP_W'(HOLD_CYCLES))
                                      : (rp_cnt == RP_W'(REPEAT_CYCLES)));
  assign rpt_up  = rp_fire && deb[0] && !deb[1];
  assign rpt_dn  = rp_fire && deb[1] && !deb[0];

  // Hold/repeat timer: restarts on each up/down press, cleared on release
  // or whenever the FSM is outside IDLE.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rp_act  <= 1'b0;
      rp_hold <= 1'b0;
      rp_cnt  <= '0;
    end else if (state != IDLE || !(deb[0] || deb[1])) begin
      rp_act  <= 1'b0;
      rp_hold <= 1'b0;
      rp_cnt  <= '0;
    end else if (press[0] || press[1]) begin
      rp_act  <= 1'b1;
      rp_hold <= 1'b1;
      rp_cnt  <= RP_W'(1);
    end else if (rp_fire) begin
      rp_hold <= 1'b0;
      rp_cnt  <= RP_W'(1);
    end else if (rp_act) begin
      rp_cnt  <= rp_cnt + 1'b1;
    end
  end
`else
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif

  assign req_up = press[0] || rpt_up;
  assign req_dn = press[1] || rpt_dn;

  // Decisions use the level including the pulse currently on the outputs,
  // since level_o only catches up one cycle after each pulse.
  assign level_nx   = level_o + {2'b00, up_o} - {2'b00, down_o};
  assign unmute_tgt = (saved_r == 3'd0) ? 3'd1 : saved_r;

  // Next-state and next-pulse logic.
  always_comb begin
    state_n = state;
    saved_n = saved_r;
    tmr_n   = tmr;
    up_n    = 1'b0;
    down_n  = 1'b0;
    case (state)
      IDLE: begin
        if (press[2]) begin
          saved_n = level_nx;
          if (level_nx == 3'd7) begin
            state_n = MUTED;
          end else begin
            state_n = RAMP_MUTE;
            up_n    = 1'b1;
            tmr_n   = RT_MAX;
          end
        end else if (req_up && !req_dn) begin
          up_n = (level_nx != 3'd7);
        end else if (req_dn && !req_up) begin
          down_n = (level_nx > 3'd1);
        end
      end
      RAMP_MUTE: begin
        if (level_nx == 3'd7) begin
          state_n = MUTED;
        end else if (tmr == '0) begin
          up_n  = 1'b1;
          tmr_n = RT_MAX;
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      MUTED: begin
        if (press[2]) begin
          if (level_nx == saved_r) begin
            state_n = IDLE;
          end else begin
            state_n = RAMP_UNMUTE;
            down_n  = 1'b1;
            tmr_n   = RT_MAX;
          end
        end
      end
      RAMP_UNMUTE: begin
        if (level_nx == unmute_tgt) begin
          state_n = IDLE;
        end else if (tmr == '0) begin
          down_n = (level_nx > 3'd1);
          tmr_n  = RT_MAX;
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, shadow level and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      saved_r <= '0;
      tmr     <= '0;
      up_o    <= 1'b0;
      down_o  <= 1'b0;
      level_o <= '0;
      muted_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state   <= state_n;
      saved_r <= saved_n;
      tmr     <= tmr_n;
      up_o    <= up_n;
      down_o  <= down_n;
      level_o <= level_nx;
      muted_o <= (state_n == MUTED);
      busy_o  <= (state_n == RAMP_MUTE) || (state_n == RAMP_UNMUTE);
    end
  end

endmodule

// File: doc/volume_ctrl.md
# volume_ctrl

Front-panel controller that sequences the `volume` attenuator.
- Debounces three raw push-buttons (up, down, mute).
- Converts presses into single-cycle `up_i`/`down_i` step pulses for `volume`.
- Keeps a shadow copy of the attenuation shift for display.
- Implements a timed mute/unmute ramp, so the level moves one step per ramp interval instead of jumping.
- Sits between the board button inputs and `volume`. Both blocks share one clock and one reset.

## Interface
- `DEBOUNCE_CYCLES`, default 16: cycles a synchronized button must hold its new value before the debounced state changes; minimum 2.
- `RAMP_CYCLES`, default 8: spacing between successive ramp pulses; minimum 1.
- `HOLD_CYCLES`, default 64: debounced hold time before auto-repeat starts.
- `REPEAT_CYCLES`, default 32: auto-repeat pulse period.
- `clk_i` input 1: clock; single clock domain.
- `reset_i` input 1: synchronous, active-high reset.
- `up_btn_i` input 1: raw up button, asynchronous, bouncy.
- `down_btn_i` input 1: raw down button, asynchronous, bouncy.
- `mute_btn_i` input 1: raw mute toggle button, asynchronous, bouncy.
- `up_o` output 1: one-cycle pulse to `volume.up_i`; increases the attenuation shift by 1.
- `down_o` output 1: one-cycle pulse to `volume.down_i`; decreases the attenuation shift by 1.
- `level_o` output 3: shadow attenuation shift, 0..7.
- `muted_o` output 1: high while in MUTED.
- `busy_o` output 1: high while a ramp is in progress.

## Operation
- **Input conditioning:** each raw button passes through a 2-flop synchronizer, then a per-button saturating debounce counter.
  - The counter clears whenever the synchronized value equals the debounced state.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced state flips.
  - A rising edge of a debounced state is a "press".
- **Shadow level tracking:** mirrors the `volume` step rules exactly.
  - An `up_o` pulse increments the level only if level < 7.
  - A `down_o` pulse decrements the level only if level > 1.
  - The controller suppresses pulses that would not change the level, so `up_o` never fires at 7 and `down_o` never fires at ≤1.
- **Pulse invariants:**
  - `up_o` and `down_o` are never high in the same cycle.
  - Each pulse is exactly one cycle wide.
- **State machine:** IDLE, RAMP_MUTE, MUTED, RAMP_UNMUTE.
  - **IDLE:**
    - Up press gives `up_o`; down press gives `down_o`.
    - Simultaneous up and down presses in the same cycle produce no pulse.
    - Mute press saves `level_o` into `saved_r`. It goes to MUTED if the level is 7, otherwise to RAMP_MUTE.
    - Mute press has priority over a same-cycle up or down press.
  - **RAMP_MUTE:**
    - Issues `up_o` on the first cycle in the state, then every `RAMP_CYCLES` cycles.
    - Goes to MUTED on the cycle the level becomes 7.
  - **MUTED:**
    - Up and down presses are ignored.
    - Mute press goes to RAMP_UNMUTE, or to IDLE if `level_o == saved_r`.
  - **RAMP_UNMUTE:**
    - Issues `down_o` on the same schedule as RAMP_MUTE.
    - Goes to IDLE on the cycle the level equals `saved_r`.
    - If `saved_r` is 0, ramps to 1 and exits, because the level floor is 1 once left.
  - **Both ramp states:** all presses, including mute, are ignored.

## Timing
- **Reset:** all outputs 0; FSM in IDLE; `saved_r`, debounce counters and synchronizers cleared.
  - Reset asserted mid-ramp aborts the ramp.
  - `volume` shares `reset_i`, so the shadow level stays consistent.
- **Press latency:** a raw button held clean high from cycle t gives `up_o`/`down_o` high in exactly cycle t+DEBOUNCE_CYCLES+3.
- **Mute latency:** a mute press taken in IDLE at cycle p gives `busy_o` from cycle p+1 and the first ramp `up_o` in cycle p+1.
- **Ramp spacing:** consecutive ramp pulses are exactly `RAMP_CYCLES` cycles apart.
  - `busy_o` drops in the cycle after the final pulse.
  - `muted_o` rises in that same cycle.
- **Bounce rejection:** a glitch shorter than `DEBOUNCE_CYCLES` cycles on the synchronized signal produces no press.
- **Output registers:** `level_o` updates in the cycle after the pulse. All outputs are registered.

## Configuration
- **`VOLUME_CTRL_AUTOREPEAT_EN` defined:**
  - In IDLE, a debounced up or down held for `HOLD_CYCLES` cycles after its press emits a repeat pulse.
  - Further repeat pulses follow every `REPEAT_CYCLES` cycles while the button is held.
  - Repeat pulses are subject to the same saturation suppression and both-held cancellation.
  - Repeating stops on release or on any FSM state change.
- **Macro undefined:** one pulse per press only; the hold/repeat counters are not instantiated and `HOLD_CYCLES`/`REPEAT_CYCLES` are unused.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `RAMP_CYCLES`=3.
- **Clean press:** after reset, hold `up_btn_i` high from cycle 20 → a single `up_o` pulse at cycle 27; `level_o`=1 at cycle 28; no further pulse while held (autorepeat off).
- **Bounce and saturation:**
  - Toggle `down_btn_i` every 2 cycles for 20 cycles → no `down_o` ever.
  - Eight clean up presses → seven `up_o` pulses; `level_o` stops at 7.
- **Simultaneous presses:** press up and down with identical timing → no pulse, level unchanged.
- **Mute ramp:** from level 3, press mute → `up_o` at p+1, p+4, p+7, p+10; `muted_o` at p+11 with level 7.
  - Then press mute → `down_o` ×4 spaced 3 cycles apart, ending at level 3 in IDLE.
  - Up presses during the ramps and during MUTED produce no pulses.
- **Reset mid-ramp:** assert `reset_i` one cycle during RAMP_MUTE → next cycle all outputs 0, IDLE, `level_o`=0.
- **Autorepeat (macro defined, `HOLD_CYCLES`=10, `REPEAT_CYCLES`=5):** hold up → pulses at press, press+10, press+15, press+20 until level 7.
